channel_sum4_reduce: RTL and testbench



---
 rtl/channel_sum4_reduce.sv | 142 ++++++++++++++
 tb/tb_channel_sum4_reduce.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_sum4_reduce.sv
// channel_sum4_reduce
//   Sequential reduction block in the style of an HLS-generated loop. It pops
//   N words from an input FIFO channel, sums them with a wrapping adder and
//   pushes the single result to an output FIFO channel. After the push it
//   raises a sticky done flag.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   in_out_data       : data word from the input channel. It is sampled the
//                       cycle after the pop strobe.
//   in_read_ready     : input channel has a word available
//   in_write_ready    : unused
//   in_read_valid     : pop strobe to the input channel
//   in_in_data, in_write_valid, in_rst : tied to 0
//   out_out_data, out_read_ready       : unused
//   out_write_ready   : output channel can accept a word
//   out_in_data       : accumulator value; holds the final sum when pushed
//   out_write_valid   : push strobe to the output channel
//   out_read_valid, out_rst            : tied to 0
//   valid             : done flag, held until reset
module channel_sum4_reduce #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic             in_read_valid,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_write_valid,
  output logic             in_rst,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_write_valid,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             valid
);

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  lt;
  logic [31:0]       idx;
  logic              exit_flag;
  logic [1:0]        lb;

  logic [31:0]       iter_base;
  logic [31:0]       iter_next;
  logic              iter_last;
  logic              unused_inputs;

  // The side of each channel that this block does not use is tied off.
  // The inputs on those sides are folded into one signal so that it is
  // clear they are intentionally ignored.
  assign in_in_data     = '0;
  assign in_write_valid = 1'b0;
  assign in_rst         = 1'b0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;
  assign unused_inputs  = ^{in_write_ready, out_out_data, out_read_ready};

  // Loop-counter datapath used at the loop head.
  // The last-block register tells us whether we are entering the loop from
  // the preheader (LB = 0, counter starts from 0) or coming around the back
  // edge (LB = 2, continue from the stored counter). The exit compare is
  // done on the incremented value so the flag is ready by the latch block.
  assign iter_base = (lb == 2'd0) ? 32'd0 : idx;
  assign iter_next = iter_base + 32'd1;
  assign iter_last = (iter_next == 32'(N));

  // State and datapath registers.
  // Every register clears on reset, including mid-loop, so a new run never
  // sees anything left over from an aborted one. Each state updates only
  // the registers that belong to its basic block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S0;
      acc       <= '0;
      lt        <= '0;
      idx       <= '0;
      exit_flag <= 1'b0;
      lb        <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        S0: acc <= '0;
        S1: lb  <= 2'd0;
        S2: begin
          if (in_read_ready) begin
            lt        <= acc;
            idx       <= iter_next;
            exit_flag <= iter_last;
          end
        end
        S4: acc <= lt + in_out_data;
        S5: lb  <= 2'd2;
        default: ;
      endcase
    end
  end

  // Next-state logic and strobes.
  // The strobes depend only on the current state. in_read_ready is looked
  // at only in the loop head and out_write_ready only in the wait-for-output
  // state. S8 is terminal, so the done flag stays high until reset.
  always_comb begin
    state_next      = state;
    in_read_valid   = 1'b0;
    out_write_valid = 1'b0;
    valid           = 1'b0;
    case (state)
      S0: state_next = S1;
      S1: state_next = S2;
      S2: if (in_read_ready) state_next = S3;
      S3: begin
        in_read_valid = 1'b1;
        state_next    = S4;
      end
      S4: state_next = S5;
      S5: state_next = exit_flag ? S6 : S2;
      S6: if (out_write_ready) state_next = S7;
      S7: begin
        out_write_valid = 1'b1;
        state_next      = S8;
      end
      S8: valid = 1'b1;
      default: state_next = S0;
    endcase
  end

  assign out_in_data = acc;

endmodule

// File: tb/tb_channel_sum4_reduce.sv
module tb_channel_sum4_reduce;

  localparam int WIDTH = 32;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_out_data;
  logic             in_read_ready;
  logic             in_write_ready;
  logic             in_read_valid;
  logic [WIDTH-1:0] in_in_data;
  logic             in_write_valid;
  logic             in_rst;
  logic [WIDTH-1:0] out_out_data;
  logic             out_read_ready;
  logic             out_write_ready;
  logic [WIDTH-1:0] out_in_data;
  logic             out_write_valid;
  logic             out_read_valid;
  logic             out_rst;
  logic             valid;

  channel_sum4_reduce #(.WIDTH(WIDTH), .N(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_out_data     (in_out_data),
    .in_read_ready   (in_read_ready),
    .in_write_ready  (in_write_ready),
    .in_read_valid   (in_read_valid),
    .in_in_data      (in_in_data),
    .in_write_valid  (in_write_valid),
    .in_rst          (in_rst),
    .out_out_data    (out_out_data),
    .out_read_ready  (out_read_ready),
    .out_write_ready (out_write_ready),
    .out_in_data     (out_in_data),
    .out_write_valid (out_write_valid),
    .out_read_valid  (out_read_valid),
    .out_rst         (out_rst),
    .valid           (valid)
  );

  // One vector is one run: four words, read-ready and write-ready low
  // windows given in run cycles, the expected sum, the expected push cycle
  // and the expected pop cycles.
  typedef struct packed {
    logic [3:0][31:0] w;
    int               rdStart;
    int               rdLen;
    int               wrStart;
    int               wrLen;
    logic [31:0]      sum;
    int               pushCyc;
    logic [3:0][15:0] pops;
  } vec_t;

  typedef struct packed {
    logic [31:0] sum;
    int          cyc;
  } exp_t;

  vec_t        vecs[6];
  logic [31:0] wordQ[$];
  int          popCycQ[$];
  exp_t        expQ[$];

  int checks;
  int errors;
  int cyc;
  int rdStart, rdLen, wrStart, wrLen;
  int popCount, pushCount, firstValid;
  bit popSeen;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run cycle counter. Cycle 0 is the first cycle with reset released.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Compare one value and report it.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Advance one cycle. At the negedge, drive the inputs and watch the
  // strobes. The input channel behaves like a FIFO with registered read
  // data, so a popped word becomes visible the cycle after the pop. In all
  // other cycles the data bus carries a garbage value.
  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    if (popSeen && wordQ.size() > 0) in_out_data = wordQ.pop_front();
    else                             in_out_data = GARBAGE;
    popSeen         = 1'b0;
    in_read_ready   = !(cyc >= rdStart && cyc < rdStart + rdLen);
    out_write_ready = !(cyc >= wrStart && cyc < wrStart + wrLen);
    if (!rst) begin
      if (in_read_valid) begin
        popSeen = 1'b1;
        popCount++;
        if (popCycQ.size() > 0) checkOutput("pop_cycle", cyc, popCycQ.pop_front());
        else                    checkOutput("pop_count_extra", popCount, 4);
      end
      if (out_write_valid) begin
        pushCount++;
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("push_data", out_in_data, e.sum);
          checkOutput("push_cycle", cyc, e.cyc);
        end else begin
          checkOutput("push_count_extra", pushCount, 0);
        end
      end
      if (valid && firstValid < 0) firstValid = cyc;
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] a, b, c, d,
                                 input int rs, rl, ws, wl,
                                 input logic [31:0] sum, input int push,
                                 input int p0, p1, p2, p3);
    vec_t v;
    v.w       = {d, c, b, a};
    v.rdStart = rs;
    v.rdLen   = rl;
    v.wrStart = ws;
    v.wrLen   = wl;
    v.sum     = sum;
    v.pushCyc = push;
    v.pops    = {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
    return v;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_read_valid"}, in_read_valid, 0);
    checkOutput({tag, "_out_write_valid"}, out_write_valid, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_out_in_data"}, out_in_data, 0);
    checkOutput({tag, "_tieoffs"},
                {in_in_data, in_write_valid, in_rst, out_read_valid, out_rst}, 0);
  endtask

  // Run one vector. Reset is optional, so that the reset-abort sequence can
  // release a reset it already applied. The call returns at cycle pushCyc+3.
  task automatic runVector(input vec_t v, input bit withReset, input string tag);
    rdStart = v.rdStart;
    rdLen   = v.rdLen;
    wrStart = v.wrStart;
    wrLen   = v.wrLen;
    wordQ.delete();
    popCycQ.delete();
    expQ.delete();
    popSeen = 1'b0;
    if (withReset) begin
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      checkResetState(tag);
    end
    for (int k = 0; k < 4; k++) begin
      wordQ.push_back(v.w[k]);
      popCycQ.push_back(int'(v.pops[k]));
    end
    expQ.push_back({v.sum, v.pushCyc});
    popCount   = 0;
    pushCount  = 0;
    firstValid = -1;
    rst        = 1'b0;
    while (cyc < v.pushCyc + 3) applyStimulus();
    checkOutput({tag, "_pop_count"}, popCount, 4);
    checkOutput({tag, "_push_count"}, pushCount, 1);
    checkOutput({tag, "_valid_first_cycle"}, firstValid, v.pushCyc + 1);
    checkOutput({tag, "_valid_sticky"}, valid, 1);
    checkOutput({tag, "_scoreboard_empty"}, expQ.size(), 0);
  endtask

  initial begin
    int badValid, badStrobe, badTie, badData;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    in_out_data     = GARBAGE;
    in_read_ready   = 1'b1;
    in_write_ready  = 1'b0;
    out_out_data    = '0;
    out_read_ready  = 1'b0;
    out_write_ready = 1'b1;
    rdStart = 0; rdLen = 0; wrStart = 0; wrLen = 0;
    popSeen = 1'b0;

    vecs[0] = mkVec(1, 2, 3, 4, 0, 0, 0, 0, 32'd10, 19, 3, 7, 11, 15);
    vecs[1] = mkVec(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 32'd0, 19, 3, 7, 11, 15);
    vecs[2] = mkVec(5, 5, 5, 5, 6, 5, 0, 0, 32'd20, 24, 3, 12, 16, 20);
    vecs[3] = mkVec(1, 1, 1, 1, 0, 0, 18, 3, 32'd4, 22, 3, 7, 11, 15);
    vecs[4] = mkVec(100, 200, 300, 400, 3, 3, 0, 18, 32'd1000, 19, 3, 7, 11, 15);
    vecs[5] = mkVec(32'h89AB_CDEF, 32'h7654_3210, 32'h1234_5678, 32'hFEDC_BA98,
                    0, 0, 0, 0, 32'h1111_110F, 19, 3, 7, 11, 15);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      runVector(vecs[i], 1'b1, $sformatf("v%0d", i));
    end

    // Abort a run of 9s during its third iteration. The next run must then
    // start from a clean state.
    $display("[TB] reset abort sequence");
    rdStart = 0; rdLen = 0; wrStart = 0; wrLen = 0;
    wordQ.delete();
    popCycQ.delete();
    expQ.delete();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    for (int k = 0; k < 4; k++) wordQ.push_back(32'd9);
    popCycQ.push_back(3);
    popCycQ.push_back(7);
    popCycQ.push_back(11);
    popCount   = 0;
    pushCount  = 0;
    firstValid = -1;
    rst        = 1'b0;
    while (cyc < 12) applyStimulus();
    checkOutput("abort_acc_before", out_in_data, 18);
    checkOutput("abort_pops_before", popCount, 3);
    rst = 1'b1;
    applyStimulus();
    checkResetState("abort");
    runVector(mkVec(7, 7, 7, 7, 0, 0, 0, 0, 32'd28, 19, 3, 7, 11, 15), 1'b0, "after_abort");

    // Leave the block in its done state for 20 cycles with the ready inputs
    // changing at random. Nothing may move.
    badValid = 0; badStrobe = 0; badTie = 0; badData = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      in_read_ready   = 1'($urandom_range(0, 1));
      out_write_ready = 1'($urandom_range(0, 1));
      if (valid !== 1'b1) badValid++;
      if (in_read_valid !== 1'b0 || out_write_valid !== 1'b0) badStrobe++;
      if ({in_in_data, in_write_valid, in_rst, out_read_valid, out_rst} !== '0) badTie++;
      if (out_in_data !== 32'd28) badData++;
    end
    checkOutput("done_valid_dropped_cycles", badValid, 0);
    checkOutput("done_strobe_cycles", badStrobe, 0);
    checkOutput("done_tieoff_cycles", badTie, 0);
    checkOutput("done_data_changed_cycles", badData, 0);
    checkOutput("done_extra_pops", popCount, 4);
    checkOutput("done_extra_pushes", pushCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
